// File: rtl/uart_rx_frame_engine_pkg.sv
// Shared types for the UART receive path: frame configuration, parity
// select, receiver FSM states and the error flag layout used by RX IRQ logic.
package uart_rx_frame_engine_pkg;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      EVEN = 2'b01,
      ODD  = 2'b10
   } Parity_t;

   typedef struct packed {
      logic [2:0] data_bits;   // data bits minus 5, already clamped to 0..4
      Parity_t    parity;
      logic       stop_bits;   // 0 = one stop bit, 1 = two
   } RxFrameCfg_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP1  = 3'd4,
      STOP2  = 3'd5
   } RxState_t;

   typedef struct packed {
      logic overrun;
      logic framing;
      logic parity;
   } RXIrqFlags_t;

   localparam int RXERR_PARITY_IDX  = 0;
   localparam int RXERR_FRAMING_IDX = 1;
   localparam int RXERR_OVERRUN_IDX = 2;

   // Normalise raw register values: width codes above 4 mean 9 bits, parity code 3 means none.
   function automatic RxFrameCfg_t make_cfg(input logic [2:0] db, input logic [1:0] pm,
                                            input logic sb);
      RxFrameCfg_t c;
      c.data_bits = (db > 3'd4) ? 3'd4 : db;
      case (pm)
         2'b01:   c.parity = EVEN;
         2'b10:   c.parity = ODD;
         default: c.parity = NONE;
      endcase
      c.stop_bits = sb;
      return c;
   endfunction

endpackage

// File: rtl/uart_rx_frame_engine_baud_tick.sv
// uart_baud_tick: oversample tick divider shared by the RX and TX engines.
// A one-cycle tick fires every div+1 enabled cycles; clear restarts the count.
module uart_baud_tick #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   // Next count and tick; >= keeps the divider sane if div shrinks mid-count.
   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (en) begin
         if (cnt_q >= div) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Divider count register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_frame_engine.sv
// uart_rx_frame_engine: oversampling UART receiver with runtime frame format
// (5..9 data bits, none/even/odd parity, 1 or 2 stop bits), valid/ready output
// and parity/framing/overrun error pulses.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling around
// each bit centre (one tick of extra latency); otherwise one sample at mid-bit.
// Handshake: rx_data is stable while rx_valid=1; a word transfers in any cycle
// with rx_valid && rx_ready, and rx_valid drops on the following edge unless a
// new word is delivered in that same cycle.
module uart_rx_frame_engine
   import uart_rx_frame_engine_pkg::*;
#(
   parameter int MAX_DATA_W = 9,
   parameter int OVERSAMPLE = 16,
   parameter int DIV_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [DIV_W-1:0]      baud_div,
   input  logic [2:0]            data_bits,
   input  logic [1:0]            parity_mode,
   input  logic                  stop_bits,
   input  logic                  rx,
   output logic [MAX_DATA_W-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  err_parity,
   output logic                  err_framing,
   output logic                  err_overrun,
   output logic                  busy
);

   localparam int OS_W = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0] BIT_LAST = OS_W'(OVERSAMPLE - 1);

   logic                  sync1_q, sync2_q, prev_q;
   RxState_t              state_q, state_d;
   RxFrameCfg_t           cfg_q, cfg_d;
   logic [OS_W-1:0]       os_q, os_d;
   logic [3:0]            idx_q, idx_d;
   logic [MAX_DATA_W-1:0] shift_q, shift_d, data_q, data_d;
   logic                  par_q, par_d, perr_q, perr_d, ferr_q, ferr_d;
   logic                  valid_q, valid_d;
   RXIrqFlags_t           err_q, err_d;
   logic [2:0]            err_vec;
   logic                  tick, start_det, bit_v, at_sample, deliver, frame_ferr;
   logic [OS_W-1:0]       sample_pt;

`ifdef UART_RX_MAJORITY_EN
   localparam logic [OS_W-1:0] START_LAST = OS_W'(OVERSAMPLE / 2);
   logic [1:0] hist_q;

   // Last two tick samples; with the current one they form the mid-1/mid/mid+1 vote.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       hist_q <= 2'b11;
      else if (tick) hist_q <= {hist_q[0], sync2_q};
   end

   assign bit_v = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
`else
   localparam logic [OS_W-1:0] START_LAST = OS_W'(OVERSAMPLE / 2 - 1);
   assign bit_v = sync2_q;
`endif

   assign start_det = enable && (state_q == IDLE) && prev_q && !sync2_q;
   assign sample_pt = (state_q == START) ? START_LAST : BIT_LAST;
   assign at_sample = tick && (os_q == sample_pt);

   uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .en    (enable && (state_q != IDLE)),
      .clear (start_det),
      .div   (baud_div),
      .tick  (tick)
   );

   // Frame FSM, deserialiser, delivery and handshake next-state logic.
   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      os_d       = os_q;
      idx_d      = idx_q;
      shift_d    = shift_q;
      par_d      = par_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      data_d     = data_q;
      valid_d    = valid_q;
      err_d      = '0;
      deliver    = 1'b0;
      frame_ferr = 1'b0;
      if (valid_q && rx_ready) valid_d = 1'b0;
      if (tick) os_d = at_sample ? '0 : os_q + 1'b1;
      if (!enable) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (start_det) begin
               cfg_d   = make_cfg(data_bits, parity_mode, stop_bits);
               state_d = START;
               os_d    = '0;
               idx_d   = '0;
               shift_d = '0;
               par_d   = 1'b0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
            START: if (at_sample) state_d = bit_v ? IDLE : DATA;
            DATA: if (at_sample) begin
               for (int i = 0; i < MAX_DATA_W; i++)
                  if (idx_q == 4'(i)) shift_d[i] = bit_v;
               par_d = par_q ^ bit_v;
               idx_d = idx_q + 1'b1;
               if (idx_q == ({1'b0, cfg_q.data_bits} + 4'd4))
                  state_d = (cfg_q.parity == NONE) ? STOP1 : PARITY;
            end
            PARITY: if (at_sample) begin
               perr_d  = ((par_q ^ bit_v) != (cfg_q.parity == ODD));
               state_d = STOP1;
            end
            STOP1: if (at_sample) begin
               ferr_d = !bit_v;
               if (cfg_q.stop_bits) begin
                  state_d = STOP2;
               end else begin
                  state_d    = IDLE;
                  deliver    = 1'b1;
                  frame_ferr = !bit_v;
               end
            end
            STOP2: if (at_sample) begin
               state_d    = IDLE;
               deliver    = 1'b1;
               frame_ferr = ferr_q | !bit_v;
            end
            default: state_d = IDLE;
         endcase
      end
      // A word arriving while the previous one is still unaccepted is dropped.
      if (deliver) begin
         if (!valid_q || rx_ready) begin
            data_d        = shift_q;
            valid_d       = 1'b1;
            err_d.parity  = perr_q;
            err_d.framing = frame_ferr;
         end else begin
            err_d.overrun = 1'b1;
         end
      end
   end

   // Synchroniser, edge history and all engine state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         cfg_q   <= '0;
         os_q    <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= '0;
      end else begin
         sync1_q <= rx;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cfg_q   <= cfg_d;
         os_q    <= os_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign err_vec     = err_q;
   assign err_parity  = err_vec[RXERR_PARITY_IDX];
   assign err_framing = err_vec[RXERR_FRAMING_IDX];
   assign err_overrun = err_vec[RXERR_OVERRUN_IDX];
   assign rx_data     = data_q;
   assign rx_valid    = valid_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_engine.sv
// Bench for uart_rx_frame_engine: 16x oversample, baud_div=3 (64 clk per bit).
module tb_uart_rx_frame_engine;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b1;
   logic [15:0] baud_div = 16'd3;
   logic [2:0]  data_bits = 3'd3;
   logic [1:0]  parity_mode = 2'b00;
   logic        stop_bits = 1'b0;
   logic        rx = 1'b1;
   logic [8:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready = 1'b1;
   logic        err_parity, err_framing, err_overrun, busy;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int last_rise_cyc = 0;
   logic valid_prev = 1'b0;

   // entries are {overrun, framing, parity, data[8:0]}
   logic [11:0] exp_q[$];
   logic [11:0] obs_q[$];

   uart_rx_frame_engine dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .baud_div    (baud_div),
      .data_bits   (data_bits),
      .parity_mode (parity_mode),
      .stop_bits   (stop_bits),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .err_parity  (err_parity),
      .err_framing (err_framing),
      .err_overrun (err_overrun),
      .busy        (busy)
   );

   // clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: record every word delivery or error pulse
   always @(negedge clk) begin
      if (rst) begin
         valid_prev = 1'b0;
      end else begin
         if ((rx_valid && !valid_prev) || err_parity || err_framing || err_overrun) begin
            obs_q.push_back({err_overrun, err_framing, err_parity, rx_data});
            last_rise_cyc = cyc;
         end
         valid_prev = rx_valid;
      end
   end

   // drive one serial frame, LSB first; cut>0 stops after that many bit times
   task automatic send_frame(input logic [8:0] val, input logic [2:0] db, input logic [1:0] pm,
                             input logic sb, input bit bad_par, input bit bad_stop,
                             input bit scramble, input int cut);
      int nb, n;
      logic [15:0] fr;
      logic p;
      nb = (db > 3'd4) ? 9 : int'(db) + 5;
      data_bits = db;
      parity_mode = pm;
      stop_bits = sb;
      fr = '0;
      n = 1;
      p = 1'b0;
      for (int i = 0; i < nb; i++) begin
         fr[n] = val[i];
         p = p ^ val[i];
         n++;
      end
      if (pm == 2'b01 || pm == 2'b10) begin
         fr[n] = p ^ (pm == 2'b10) ^ bad_par;
         n++;
      end
      fr[n] = !bad_stop;
      n++;
      if (sb) begin
         fr[n] = 1'b1;
         n++;
      end
      if (cut > 0) n = cut;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1 rx = fr[i];
         if (i == 0) start_cyc = cyc;
         if (i == 1 && scramble) begin
            data_bits = 3'd0;
            parity_mode = 2'b10;
            stop_bits = 1'b1;
         end
         repeat (63) @(posedge clk);
      end
      @(posedge clk);
      #1 rx = 1'b1;
   endtask

   // bounded wait for n observed events
   task automatic wait_obs(input int n);
      for (int i = 0; i < 3000; i++) begin
         if (obs_q.size() >= n) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rx_data, rx_valid, err_parity, err_framing, err_overrun, busy} !== 14'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0",
                  {rx_data, rx_valid, err_parity, err_framing, err_overrun, busy});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if ({rx_valid, busy} !== 2'b00) begin
         failures++;
         $display("FAIL reset_release got=%b exp=00", {rx_valid, busy});
      end
   endtask

   task automatic test_8n1;
      logic [11:0] e, o;
      int lat;
      exp_q.push_back({3'b000, 9'h0A5});
      send_frame(9'h0A5, 3'd3, 2'b00, 1'b0, 0, 0, 0, 0);
      wait_obs(exp_q.size());
      lat = last_rise_cyc - start_cyc;
      checks++;
      if (lat < 608 || lat > 624) begin
         failures++;
         $display("FAIL 8n1_latency got=%0d exp=608..624", lat);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL 8n1_word got=%h exp=%h", o, e);
         end
      end
      checks++;
      if (rx_valid !== 1'b0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL 8n1_after got=%b/%0d exp=0/0", rx_valid, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_parity;
      logic [11:0] e, o;
      exp_q.push_back({3'b001, 9'h035});
      send_frame(9'h035, 3'd2, 2'b01, 1'b0, 1, 0, 1, 0);
      wait_obs(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL parity_word got=%h exp=%h", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL parity_extra got=%0d exp=0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_framing;
      logic [11:0] e, o;
      exp_q.push_back({3'b010, 9'h03C});
      send_frame(9'h03C, 3'd3, 2'b00, 1'b0, 0, 1, 0, 0);
      repeat (64) @(posedge clk);
      exp_q.push_back({3'b000, 9'h05A});
      send_frame(9'h05A, 3'd3, 2'b00, 1'b0, 0, 0, 0, 0);
      exp_q.push_back({3'b010, 9'h000});
      send_frame(9'h000, 3'd3, 2'b00, 1'b0, 0, 1, 0, 0);
      wait_obs(exp_q.size());
      repeat (128) @(posedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL framing_word got=%h exp=%h", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL framing_extra got=%0d exp=0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_back_to_back;
      logic [11:0] e, o;
      rx_ready = 1'b0;
      exp_q.push_back({3'b000, 9'h011});
      send_frame(9'h011, 3'd3, 2'b11, 1'b0, 0, 0, 0, 0);
      exp_q.push_back({3'b100, 9'h011});
      send_frame(9'h022, 3'd3, 2'b00, 1'b0, 0, 0, 0, 0);
      wait_obs(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL overrun_event got=%h exp=%h", o, e);
         end
      end
      @(negedge clk);
      checks++;
      if ({rx_valid, rx_data} !== {1'b1, 9'h011}) begin
         failures++;
         $display("FAIL overrun_held got=%b/%h exp=1/011", rx_valid, rx_data);
      end
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL overrun_handshake got=%b/%0d exp=0/0", rx_valid, obs_q.size());
         obs_q.delete();
      end
      rx_ready = 1'b1;
   endtask

   task automatic test_false_start;
      @(posedge clk);
      #1 rx = 1'b0;
      repeat (16) @(posedge clk);
      #1 rx = 1'b1;
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL false_start_busy got=%b exp=1", busy);
      end
      repeat (60) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rx_valid !== 1'b0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL false_start_idle got=%b/%b/%0d exp=0/0/0", busy, rx_valid, obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_enable_abort;
      logic [11:0] e, o;
      rx_ready = 1'b0;
      exp_q.push_back({3'b000, 9'h05A});
      send_frame(9'h05A, 3'd3, 2'b00, 1'b0, 0, 0, 0, 0);
      wait_obs(exp_q.size());
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
      checks++;
      if (o !== e) begin
         failures++;
         $display("FAIL abort_first got=%h exp=%h", o, e);
      end
      send_frame(9'h077, 3'd3, 2'b00, 1'b0, 0, 0, 0, 4);
      #1 enable = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if ({busy, rx_valid, rx_data} !== {1'b0, 1'b1, 9'h05A}) begin
         failures++;
         $display("FAIL abort_state got=%b/%b/%h exp=0/1/05a", busy, rx_valid, rx_data);
      end
      @(posedge clk);
      #1 enable = 1'b1;
      repeat (700) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL abort_quiet got=%b/%0d exp=0/0", busy, obs_q.size());
         obs_q.delete();
      end
      @(posedge clk);
      #1 rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (rx_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_handshake got=%b exp=0", rx_valid);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [11:0] e, o;
      rx_ready = 1'b0;
      exp_q.push_back({3'b000, 9'h00F});
      send_frame(9'h00F, 3'd3, 2'b00, 1'b0, 0, 0, 0, 0);
      wait_obs(exp_q.size());
      send_frame(9'h1C3, 3'd4, 2'b10, 1'b1, 0, 0, 0, 6);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({rx_data, rx_valid, err_parity, err_framing, err_overrun, busy} !== 14'd0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h exp=0",
                  {rx_data, rx_valid, err_parity, err_framing, err_overrun, busy});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      rx_ready = 1'b1;
      exp_q.push_back({3'b000, 9'h1C3});
      send_frame(9'h1C3, 3'd7, 2'b10, 1'b1, 0, 0, 0, 0);
      wait_obs(exp_q.size());
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 12'hxxx;
         checks++;
         if (o !== e) begin
            failures++;
            $display("FAIL midreset_word got=%h exp=%h", o, e);
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL midreset_extra got=%0d exp=0", obs_q.size());
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_framing();
      test_back_to_back();
      test_false_start();
      test_enable_abort();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
